// File: rtl/hazard_control_unit.sv
// Pipeline hazard sequencer: load-use bubble, taken-branch squash, memory-wait freeze with timeout trap.
// Optional stall statistics counter built only when HAZARD_CTRL_STATS_EN is defined.
module hazard_control_unit #(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        id_a_valid,
    input  logic [3:0]  id_a,
    input  logic        id_b_valid,
    input  logic [3:0]  id_b,
    input  logic        ex_mem_read,
    input  logic [3:0]  ex_dst,
    input  logic        ex_branch_taken,
    input  logic        mem_access,
    input  logic        mem_ready,
    output logic        pc_en,
    output logic        ifid_en,
    output logic        ifid_flush,
    output logic        idex_en,
    output logic        idex_bubble,
    output logic        exmem_en,
    output logic        memwb_bubble,
    output logic        error,
    output logic [1:0]  state,
    output logic [15:0] stall_count
);

    typedef enum logic [1:0] {
        ST_RUN        = 2'b00,
        ST_LOAD_STALL = 2'b01,
        ST_MEM_WAIT   = 2'b10,
        ST_ERROR      = 2'b11
    } state_t;

    localparam logic [7:0] TIMEOUT = 8'(MEM_TIMEOUT);

    state_t     state_q, state_d;
    logic [7:0] wait_cnt_q, wait_cnt_d;
    logic       error_q, error_d;

    logic load_use, mem_stall;
    logic freeze, squash, hold_front, trapped;

    assign load_use  = ex_mem_read &
                       ((id_a_valid & (id_a == ex_dst)) | (id_b_valid & (id_b == ex_dst)));
    assign mem_stall = mem_access & ~mem_ready;

    always_comb begin
        freeze     = 1'b0;
        squash     = 1'b0;
        hold_front = 1'b0;
        trapped    = 1'b0;
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        error_d    = error_q;
        // While rst is high the controls stay at their defaults; the register reset wins anyway.
        if (!rst) begin
            case (state_q)
                ST_RUN, ST_LOAD_STALL: begin
                    if (mem_stall) begin
                        freeze     = 1'b1;
                        state_d    = ST_MEM_WAIT;
                        wait_cnt_d = 8'd1;
                    end else if (ex_branch_taken) begin
                        squash  = 1'b1;
                        state_d = ST_RUN;
                    end else if (load_use) begin
                        hold_front = 1'b1;
                        state_d    = ST_LOAD_STALL;
                    end else begin
                        state_d = ST_RUN;
                    end
                end
                ST_MEM_WAIT: begin
                    if (mem_ready) begin
                        state_d    = ST_RUN;
                        wait_cnt_d = 8'd0;
                    end else begin
                        freeze = 1'b1;
                        if (wait_cnt_q == TIMEOUT) begin
                            state_d = ST_ERROR;
                            error_d = 1'b1;
                        end else begin
                            wait_cnt_d = wait_cnt_q + 8'd1;
                        end
                    end
                end
                default: begin
                    trapped = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_RUN;
            wait_cnt_q <= 8'd0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            error_q    <= error_d;
        end
    end

    assign pc_en        = ~(freeze | hold_front | trapped);
    assign ifid_en      = ~(freeze | hold_front | trapped);
    assign ifid_flush   = squash;
    assign idex_en      = ~(freeze | trapped);
    assign idex_bubble  = squash | hold_front;
    assign exmem_en     = ~(freeze | trapped);
    assign memwb_bubble = freeze | trapped;
    assign error        = error_q & ~rst;
    assign state        = state_q;

`ifdef HAZARD_CTRL_STATS_EN
    logic [15:0] stall_count_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_count_q <= 16'h0000;
        end else if (!pc_en && (state_q != ST_ERROR) && (stall_count_q != 16'hFFFF)) begin
            stall_count_q <= stall_count_q + 16'h0001;
        end
    end

    assign stall_count = stall_count_q;
`else
    assign stall_count = 16'h0000;
`endif

endmodule

// File: tb/tb_hazard_control_unit.sv
// Bench for hazard_control_unit: a cycle model pushes expected controls per driven cycle, popped at negedge.
module tb_hazard_control_unit;

    localparam int TMO = 4;
`ifdef HAZARD_CTRL_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    // Control vector order: pc_en ifid_en ifid_flush idex_en idex_bubble exmem_en memwb_bubble error
    localparam logic [7:0] C_DEF = 8'b1101_0100;
    localparam logic [7:0] C_FRZ = 8'b0000_0010;
    localparam logic [7:0] C_ERR = 8'b0000_0011;
    localparam logic [7:0] C_BR  = 8'b1111_1100;
    localparam logic [7:0] C_LU  = 8'b0001_1100;

    logic clk = 1'b0;
    logic rst, id_a_valid, id_b_valid, ex_mem_read, ex_branch_taken, mem_access, mem_ready;
    logic [3:0] id_a, id_b, ex_dst;
    logic pc_en, ifid_en, ifid_flush, idex_en, idex_bubble, exmem_en, memwb_bubble, error;
    logic [1:0] state;
    logic [15:0] stall_count;

    always #5 clk = ~clk;

    hazard_control_unit #(.MEM_TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst),
        .id_a_valid(id_a_valid), .id_a(id_a), .id_b_valid(id_b_valid), .id_b(id_b),
        .ex_mem_read(ex_mem_read), .ex_dst(ex_dst), .ex_branch_taken(ex_branch_taken),
        .mem_access(mem_access), .mem_ready(mem_ready),
        .pc_en(pc_en), .ifid_en(ifid_en), .ifid_flush(ifid_flush), .idex_en(idex_en),
        .idex_bubble(idex_bubble), .exmem_en(exmem_en), .memwb_bubble(memwb_bubble),
        .error(error), .state(state), .stall_count(stall_count)
    );

    typedef struct packed {
        logic       rst;
        logic       acc;
        logic       rdy;
        logic       br;
        logic       ld;
        logic [3:0] dst;
        logic       av;
        logic [3:0] a;
        logic       bv;
        logic [3:0] b;
    } stim_t;

    typedef struct {
        string       tag;
        logic [7:0]  ctl;
        logic [1:0]  st;
        logic [15:0] cnt;
    } exp_t;

    exp_t sbq[$];
    int total = 0;
    int bad = 0;

    int          m_state;
    int          m_wait;
    logic [15:0] m_cnt;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", tag, got, want);
        end
    endtask

    function automatic stim_t mk(input logic r, input logic acc, input logic rdy, input logic br,
                                 input logic ld, input logic [3:0] dst, input logic av,
                                 input logic [3:0] a, input logic bv, input logic [3:0] b);
        stim_t s;
        s.rst = r; s.acc = acc; s.rdy = rdy; s.br = br; s.ld = ld; s.dst = dst;
        s.av = av; s.a = a; s.bv = bv; s.b = b;
        return s;
    endfunction

    task automatic step(input string tag, input stim_t s);
        exp_t e, g;
        logic lu, ms;
        logic [7:0] c;
        int n_state, n_wait;
        logic [15:0] n_cnt;

        rst = s.rst; mem_access = s.acc; mem_ready = s.rdy; ex_branch_taken = s.br;
        ex_mem_read = s.ld; ex_dst = s.dst; id_a_valid = s.av; id_a = s.a;
        id_b_valid = s.bv; id_b = s.b;

        lu = s.ld && ((s.av && s.a == s.dst) || (s.bv && s.b == s.dst));
        ms = s.acc && !s.rdy;
        if (s.rst)             c = C_DEF;
        else if (m_state == 3) c = C_ERR;
        else if (m_state == 2) c = s.rdy ? C_DEF : C_FRZ;
        else if (ms)           c = C_FRZ;
        else if (s.br)         c = C_BR;
        else if (lu)           c = C_LU;
        else                   c = C_DEF;

        e.tag = tag; e.ctl = c; e.st = 2'(m_state); e.cnt = m_cnt;
        sbq.push_back(e);

        @(negedge clk);
        if (sbq.size() == 0) begin
            chk({tag, "_sb_empty"}, 32'd0, 32'd1);
        end else begin
            g = sbq.pop_front();
            chk({g.tag, "_ctl"}, {24'd0, pc_en, ifid_en, ifid_flush, idex_en, idex_bubble,
                                  exmem_en, memwb_bubble, error}, {24'd0, g.ctl});
            chk({g.tag, "_state"}, {30'd0, state}, {30'd0, g.st});
            chk({g.tag, "_cnt"}, {16'd0, stall_count}, {16'd0, g.cnt});
        end

        n_state = m_state; n_wait = m_wait; n_cnt = m_cnt;
        if (s.rst) begin
            n_state = 0; n_wait = 0; n_cnt = 16'd0;
        end else begin
            if (STATS && !c[7] && m_state != 3 && m_cnt != 16'hFFFF) n_cnt = m_cnt + 16'd1;
            case (m_state)
                3: n_state = 3;
                2: begin
                    if (s.rdy) begin n_state = 0; n_wait = 0; end
                    else if (m_wait == TMO) n_state = 3;
                    else n_wait = m_wait + 1;
                end
                default: begin
                    if (ms)        begin n_state = 2; n_wait = 1; end
                    else if (s.br) n_state = 0;
                    else if (lu)   n_state = 1;
                    else           n_state = 0;
                end
            endcase
        end
        @(posedge clk);
        #1;
        m_state = n_state; m_wait = n_wait; m_cnt = n_cnt;
    endtask

    stim_t idle;

    initial begin
        idle = mk(0, 0, 0, 0, 0, 4'd0, 0, 4'd0, 0, 4'd0);
        rst = 1; mem_access = 0; mem_ready = 0; ex_branch_taken = 0; ex_mem_read = 0;
        ex_dst = 0; id_a_valid = 0; id_a = 0; id_b_valid = 0; id_b = 0;
        repeat (2) @(posedge clk);
        #1;
        m_state = 0; m_wait = 0; m_cnt = 16'd0;

        step("rst_hold", mk(1, 1, 0, 1, 1, 4'd3, 1, 4'd3, 0, 4'd0));
        step("idle", idle);

        step("lu_a", mk(0, 0, 0, 0, 1, 4'd3, 1, 4'd3, 0, 4'd0));
        step("lu_stall", idle);
        step("lu_after", idle);
        step("lu_b", mk(0, 0, 0, 0, 1, 4'd7, 0, 4'd1, 1, 4'd7));
        step("lu_b_after", idle);
        step("nolu_invalid", mk(0, 0, 0, 0, 1, 4'd5, 0, 4'd5, 0, 4'd5));
        step("nolu_noload", mk(0, 0, 0, 0, 0, 4'd5, 1, 4'd5, 1, 4'd5));

        step("br_lu", mk(0, 0, 0, 1, 1, 4'd2, 1, 4'd2, 0, 4'd0));
        step("br_after", idle);

        for (int i = 0; i < 3; i++) step("mw3", mk(0, 1, 0, 0, 0, 4'd0, 0, 4'd0, 0, 4'd0));
        step("mw3_ack", mk(0, 1, 1, 0, 0, 4'd0, 0, 4'd0, 0, 4'd0));
        step("mw3_run", idle);

        step("nostall_ack", mk(0, 1, 1, 0, 0, 4'd0, 0, 4'd0, 0, 4'd0));

        for (int i = 0; i < 2; i++) step("br_mw", mk(0, 1, 0, 1, 0, 4'd0, 0, 4'd0, 0, 4'd0));
        step("br_mw_ack", mk(0, 1, 1, 1, 0, 4'd0, 0, 4'd0, 0, 4'd0));
        step("br_mw_flush", mk(0, 0, 0, 1, 0, 4'd0, 0, 4'd0, 0, 4'd0));

        step("lu_then_mem", mk(0, 0, 0, 0, 1, 4'd9, 1, 4'd9, 0, 4'd0));
        step("ls_mem_stall", mk(0, 1, 0, 0, 0, 4'd0, 0, 4'd0, 0, 4'd0));
        step("ls_mem_ack", mk(0, 1, 1, 0, 0, 4'd0, 0, 4'd0, 0, 4'd0));
        step("ls_relu", mk(0, 0, 0, 0, 1, 4'd4, 0, 4'd0, 1, 4'd4));
        step("ls_relu2", mk(0, 0, 0, 0, 1, 4'd6, 1, 4'd6, 0, 4'd0));
        step("ls_relu_end", idle);

        for (int i = 0; i < TMO + 2; i++) step("tmo", mk(0, 1, 0, 0, 0, 4'd0, 0, 4'd0, 0, 4'd0));
        step("err_rdy", mk(0, 1, 1, 1, 1, 4'd1, 1, 4'd1, 0, 4'd0));
        step("err_rst", mk(1, 0, 0, 0, 0, 4'd0, 0, 4'd0, 0, 4'd0));
        step("err_recover", idle);

        for (int i = 0; i < 300; i++) begin
            stim_t s;
            s.rst = ($urandom_range(0, 39) == 0);
            s.acc = ($urandom_range(0, 3) == 0);
            s.rdy = ($urandom_range(0, 2) != 0);
            s.br  = ($urandom_range(0, 5) == 0);
            s.ld  = ($urandom_range(0, 2) == 0);
            s.dst = 4'($urandom_range(0, 3));
            s.av  = 1'($urandom_range(0, 1));
            s.a   = 4'($urandom_range(0, 3));
            s.bv  = 1'($urandom_range(0, 1));
            s.b   = 4'($urandom_range(0, 3));
            step("rand", s);
        end

        chk("sb_drained", 32'(sbq.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
